// File: rtl/bus_pkg.sv
// Shared definitions for the internal data bus arbiter: state encoding and defaults.
package bus_pkg;

  localparam int unsigned BUS_W        = 8;
  localparam int unsigned N_MASTERS_DEF = 4;
  localparam int unsigned MAX_HOLD_DEF  = 15;
  localparam int unsigned HOLD_W        = 8;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_TURN  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/enable bundle between the bus masters and the arbiter.
interface bus_arbiter_if
  import bus_pkg::*;
#(
  parameter int unsigned N_MASTERS = N_MASTERS_DEF,
  parameter int unsigned ID_W      = 2
);
  logic [N_MASTERS-1:0] req;
  logic [N_MASTERS-1:0] en;
  logic                 busy;
  logic [ID_W-1:0]      owner_id;
  logic                 timeout;

  modport master (output req, input en, busy, owner_id, timeout);
  modport slave  (input req, output en, busy, owner_id, timeout);
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit scanning upward from ptr, wrapping.
module rr_pick #(
  parameter int unsigned N_MASTERS = 4,
  parameter int unsigned ID_W      = 2
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [ID_W-1:0]      ptr,
  output logic [N_MASTERS-1:0] onehot,
  output logic [ID_W-1:0]      idx,
  output logic                 any
);
  int unsigned pos;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    pos    = 0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      pos = (32'(ptr) + k) % N_MASTERS;
      if (!any && req[pos]) begin
        any = 1'b1;
        idx = ID_W'(pos);
      end
    end
    if (any) onehot = N_MASTERS'(1) << idx;
  end
endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with hold timeout; registered one-hot tristate enables.
// Define ARB_TURNAROUND_EN to insert one bus-idle cycle between owners.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned N_MASTERS = N_MASTERS_DEF,
  parameter int unsigned MAX_HOLD  = MAX_HOLD_DEF,
  parameter int unsigned ID_W      = 2
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.slave  bus
);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);

  arb_state_t           r_state, w_state_nx;
  logic [ID_W-1:0]      r_ptr, w_ptr_nx;
  logic [ID_W-1:0]      r_owner, w_owner_nx;
  logic [HOLD_W-1:0]    r_hold, w_hold_nx;
  logic [N_MASTERS-1:0] r_en, w_en_nx;
  logic                 r_timeout, w_timeout_nx;

  logic [N_MASTERS-1:0] w_pick_oh;
  logic [ID_W-1:0]      w_pick_idx;
  logic                 w_pick_any;
  logic                 w_others;
  logic                 w_release;
  logic                 w_arb;

  rr_pick #(
    .N_MASTERS (N_MASTERS),
    .ID_W      (ID_W)
  ) u_pick (
    .req    (bus.req),
    .ptr    (r_ptr),
    .onehot (w_pick_oh),
    .idx    (w_pick_idx),
    .any    (w_pick_any)
  );

  always_comb begin
    w_state_nx   = r_state;
    w_ptr_nx     = r_ptr;
    w_owner_nx   = r_owner;
    w_hold_nx    = r_hold;
    w_en_nx      = r_en;
    w_timeout_nx = 1'b0;
    w_release    = 1'b0;
    w_arb        = 1'b0;
    w_others     = |(bus.req & ~r_en);

    case (r_state)
      ARB_GRANT: begin
        if (!bus.req[r_owner]) begin
          w_release = 1'b1;
        // >= so a saturated hold still yields once someone else starts waiting
        end else if ((r_hold >= HOLD_LAST) && w_others) begin
          w_release    = 1'b1;
          w_timeout_nx = 1'b1;
        end else if (r_hold != HOLD_MAX) begin
          w_hold_nx = r_hold + HOLD_W'(1);
        end
      end
      default: w_arb = 1'b1;
    endcase

`ifdef ARB_TURNAROUND_EN
    if (w_release) begin
      w_state_nx = ARB_TURN;
      w_en_nx    = '0;
      w_owner_nx = '0;
    end
`else
    if (w_release) w_arb = 1'b1;
`endif

    // r_ptr already sits just past the owner, so the released owner is scanned last
    if (w_arb) begin
      if (w_pick_any) begin
        w_state_nx = ARB_GRANT;
        w_en_nx    = w_pick_oh;
        w_owner_nx = w_pick_idx;
        w_hold_nx  = '0;
        w_ptr_nx   = (w_pick_idx == ID_W'(N_MASTERS - 1)) ? '0 : w_pick_idx + ID_W'(1);
      end else begin
        w_state_nx = ARB_IDLE;
        w_en_nx    = '0;
        w_owner_nx = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ARB_IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_hold    <= '0;
      r_en      <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_ptr     <= w_ptr_nx;
      r_owner   <= w_owner_nx;
      r_hold    <= w_hold_nx;
      r_en      <= w_en_nx;
      r_timeout <= w_timeout_nx;
    end
  end

  assign bus.en       = r_en;
  assign bus.busy     = |r_en;
  assign bus.owner_id = r_owner;
  assign bus.timeout  = r_timeout;
endmodule
